// File: rtl/dsp_float_pkg.sv
// Shared float/int conversion definitions: field slices, bias constants,
// FSM and operand-class encodings, and the int16 saturating pack helper.
package dsp_float_pkg;

  localparam int unsigned SIGN_BIT  = 32'd31;
  localparam int unsigned EXP_MSB   = 32'd30;
  localparam int unsigned EXP_LSB   = 32'd23;
  localparam int unsigned FRAC_MSB  = 32'd22;
  localparam int unsigned FRAC_LSB  = 32'd0;
  localparam int unsigned SIG_WIDTH = 32'd24;

  localparam logic [7:0] FLOAT_BIAS    = 8'd127;
  localparam logic [7:0] INT16_EXP_MAX = 8'd142;
  localparam logic [7:0] EXP_SPECIAL   = 8'd255;
  // exp - this is the number of fraction bits below the binary point
  localparam logic [7:0] SHIFT_BASE    = FLOAT_BIAS + 8'(SIG_WIDTH - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_PACK   = 2'd3
  } f2i_state_e;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SMALL  = 3'd1,
    CLS_HALF   = 3'd2,
    CLS_NORM   = 3'd3,
    CLS_NEGMAX = 3'd4,
    CLS_OVF    = 3'd5,
    CLS_INF    = 3'd6,
    CLS_NAN    = 3'd7
  } f2i_class_e;

  // Returns {ovf, int16}; -32768 is representable, +32768 is not.
  function automatic logic [16:0] pack_int16(input logic sign, input logic [16:0] mag,
                                             input logic sat);
    logic [16:0] r;
    if (!sign) begin
      if (sat || (mag > 17'd32767)) r = {1'b1, 16'h7FFF};
      else                          r = {1'b0, mag[15:0]};
    end else begin
      if (sat || (mag > 17'd32768)) r = {1'b1, 16'h8000};
      else                          r = {1'b0, 16'd0 - mag[15:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Request/response bundle of the float-to-int16 converter.
interface float_to_int_if;
  logic        start;
  logic [31:0] floatin;
  logic [15:0] intout;
  logic        done;
  logic        busy;
  logic        ovf;

  modport master (output start, floatin, input intout, done, busy, ovf);
  modport slave  (input start, floatin, output intout, done, busy, ovf);
endinterface

// File: rtl/rshift_sticky24.sv
// Combinational 24-bit right shifter returning a 16-bit magnitude plus the
// round bit (last bit shifted out) and sticky bit (OR of all lower bits).
module rshift_sticky24
  import dsp_float_pkg::*;
(
  input  logic [SIG_WIDTH-1:0] sig_i,
  input  logic [4:0]           shamt_i,
  output logic [15:0]          mag_o,
  output logic                 round_o,
  output logic                 sticky_o
);
  logic [2*SIG_WIDTH-1:0] wide_s;
  logic                   unused_hi_s;

  // Bits shifted past the binary point land in the low half of wide_s.
  assign wide_s      = {sig_i, 24'd0} >> shamt_i;
  assign mag_o       = wide_s[39:24];
  assign round_o     = wide_s[23];
  assign sticky_o    = |wide_s[22:0];
  assign unused_hi_s = ^wide_s[47:40];
endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to int16 converter (IDLE/UNPACK/SHIFT/PACK, 3-cycle latency).
// Define FLOAT_TO_INT_ROUND_EN for round-half-away; default truncates toward zero.
module float_to_int
  import dsp_float_pkg::*;
(
  input logic           clk,
  input logic           reset_n,
  float_to_int_if.slave bus
);
  f2i_state_e           state_q;
  f2i_class_e           cls_q, cls_d;
  logic [31:0]          op_q;
  logic                 sign_q;
  logic [SIG_WIDTH-1:0] sig_q;
  logic [4:0]           shamt_q, shamt_d;
  logic [15:0]          intout_q;
  logic                 ovf_q, done_q, busy_q;

  logic [7:0]  exp_s;
  logic [7:0]  shamt_full_s;
  logic [22:0] frac_s;
  logic [15:0] sh_mag_s;
  logic        sh_round_s, sh_sticky_s, unused_sticky_s;
  logic        rnd_en_s, pk_sign_s, sat_s;
  logic [16:0] mag_s, pack_s;

`ifdef FLOAT_TO_INT_ROUND_EN
  assign rnd_en_s = 1'b1;
`else
  assign rnd_en_s = 1'b0;
`endif

  // Ties-away rounding only needs the round bit, never the sticky bit.
  assign unused_sticky_s = sh_sticky_s;
  assign exp_s           = op_q[EXP_MSB:EXP_LSB];
  assign frac_s          = op_q[FRAC_MSB:FRAC_LSB];
  assign shamt_full_s    = SHIFT_BASE - exp_s;

  // Classify the latched operand by exponent range.
  always_comb begin
    cls_d   = CLS_ZERO;
    shamt_d = 5'd0;
    if (exp_s == 8'd0) begin
      cls_d = CLS_ZERO;
    end else if (exp_s < (FLOAT_BIAS - 8'd1)) begin
      cls_d = CLS_SMALL;
    end else if (exp_s == (FLOAT_BIAS - 8'd1)) begin
      cls_d = CLS_HALF;
    end else if (exp_s < INT16_EXP_MAX) begin
      cls_d   = CLS_NORM;
      shamt_d = shamt_full_s[4:0];
    end else if (exp_s == EXP_SPECIAL) begin
      cls_d = (frac_s == 23'd0) ? CLS_INF : CLS_NAN;
    end else if (op_q[SIGN_BIT] && (exp_s == INT16_EXP_MAX) && (frac_s == 23'd0)) begin
      cls_d = CLS_NEGMAX;
    end else begin
      cls_d = CLS_OVF;
    end
  end

  rshift_sticky24 u_shift (
    .sig_i    (sig_q),
    .shamt_i  (shamt_q),
    .mag_o    (sh_mag_s),
    .round_o  (sh_round_s),
    .sticky_o (sh_sticky_s)
  );

  // Round, saturate and sign the shifted magnitude.
  always_comb begin
    mag_s     = 17'd0;
    sat_s     = 1'b0;
    pk_sign_s = sign_q;
    case (cls_q)
      CLS_NORM:   mag_s = {1'b0, sh_mag_s} + {16'd0, sh_round_s & rnd_en_s};
      CLS_HALF:   mag_s = {16'd0, rnd_en_s};
      CLS_NEGMAX: mag_s = 17'd32768;
      CLS_OVF,
      CLS_INF:    sat_s = 1'b1;
      CLS_NAN: begin
        sat_s     = 1'b1;
        pk_sign_s = 1'b0;
      end
      default:    mag_s = 17'd0;
    endcase
    pack_s = pack_int16(pk_sign_s, mag_s, sat_s);
  end

  // Conversion FSM with registered outputs; done is high for the PACK cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 32'd0;
      cls_q    <= CLS_ZERO;
      sign_q   <= 1'b0;
      sig_q    <= 24'd0;
      shamt_q  <= 5'd0;
      intout_q <= 16'd0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.floatin;
            busy_q  <= 1'b1;
            state_q <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          cls_q   <= cls_d;
          sign_q  <= op_q[SIGN_BIT];
          sig_q   <= {1'b1, frac_s};
          shamt_q <= shamt_d;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          intout_q <= pack_s[15:0];
          ovf_q    <= pack_s[16];
          done_q   <= 1'b1;
          state_q  <= ST_PACK;
        end
        ST_PACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.intout = intout_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule
